// File: rtl/mem_port_arbiter_if.sv
// Core-side (I/D ports) and memory-side signals of the unified memory port arbiter.
// The arbiter takes the slave view; the pipeline/memory model takes the master view.
interface mem_port_arbiter_if #(parameter int ADDR_W = 30);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_rdata;
  logic              i_ack;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_be;
  logic [31:0]       d_rdata;
  logic              d_ack;
  logic              err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic [31:0]       mem_rdata;
  logic              mem_done;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata, mem_done,
    output i_rdata, i_ack, d_rdata, d_ack, err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata, mem_done,
    input  i_rdata, i_ack, d_rdata, d_ack, err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch (I) and load/store (D) onto one single-ported memory, one
// transaction at a time, D-priority with a starvation counter and a BUSY timeout.
module mem_port_arbiter #(
  parameter int ADDR_W     = 30,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input logic             clk,
  input logic             reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic [7:0]        timer_q, timer_d;
  logic              own_i_q, own_i_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       i_rdata_q, i_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              err_q, err_d;

  logic              gnt_i, gnt_d, finish, abort;
  logic [31:0]       resp_data;

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    timer_d     = timer_q;
    own_i_d     = own_i_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ack_d     = i_ack_q;
    d_ack_d     = d_ack_q;
    err_d       = err_q;
    gnt_i       = 1'b0;
    gnt_d       = 1'b0;
    finish      = 1'b0;
    abort       = 1'b0;
    resp_data   = '0;

    if (state_q == IDLE) begin
      if (bus.i_req && starve_q >= STARVE_LIM) gnt_i = 1'b1;
      else if (bus.d_req)                      gnt_d = 1'b1;
      else if (bus.i_req)                      gnt_i = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (gnt_i) begin
          state_d     = BUSY;
          own_i_d     = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.i_addr;
          mem_wdata_d = '0;
          mem_be_d    = 4'hF;
          starve_d    = '0;
        end else if (gnt_d) begin
          state_d     = BUSY;
          own_i_d     = 1'b0;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          mem_be_d    = bus.d_we ? bus.d_be : 4'hF;
          // Only D wins that leave a fetch waiting count toward starvation.
          if (bus.i_req && starve_q != 4'hF) starve_d = starve_q + 4'd1;
        end
      end
      BUSY: begin
        timer_d = timer_q + 8'd1;
        if (bus.mem_done) begin
          finish    = 1'b1;
          resp_data = bus.mem_rdata;
        end else if (timer_q == TMO_LAST) begin
          finish = 1'b1;
          abort  = 1'b1;
        end
        if (finish) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          err_d     = abort;
          if (own_i_q) begin
            i_ack_d   = 1'b1;
            i_rdata_d = resp_data;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = mem_we_q ? 32'h0 : resp_data;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        timer_d = '0;
        i_ack_d = 1'b0;
        d_ack_d = 1'b0;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      timer_q     <= '0;
      own_i_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      timer_q     <= timer_d;
      own_i_q     <= own_i_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      err_q       <= err_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.i_ack     = i_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.err       = err_q;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified instruction/data memory between two requesters: the fetch stage (I-port) and the load/store stage (D-port).
- Serialises requests into one outstanding memory transaction at a time.
- Data accesses get priority; an anti-starvation counter guarantees fetch progress.
- Sits between the core pipeline and the memory block and absorbs the memory's variable latency.

Parameters:
ADDR_W, 30, word-address width on all ports
STARVE_MAX, 4, consecutive D grants while I waits before I is forced to win (1..15)
TIMEOUT, 64, cycles in BUSY without mem_done before the transaction is aborted (2..255)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
i_req  in  1  fetch request; held with i_addr stable until i_ack
i_addr  in  ADDR_W  fetch word address
i_rdata  out  32  fetch data, valid in the i_ack cycle
i_ack  out  1  one-cycle completion pulse for the I-port
d_req  in  1  data request; held with all d_* inputs stable until d_ack
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_W  data word address
d_wdata  in  32  store data
d_be  in  4  store byte enables; bit n enables byte n
d_rdata  out  32  load data, valid in the d_ack cycle
d_ack  out  1  one-cycle completion pulse for the D-port
err  out  1  pulses with i_ack/d_ack when that transaction timed out
mem_req  out  1  level; high for the whole BUSY state
mem_we  out  1  write strobe toward memory
mem_addr  out  ADDR_W  memory address
mem_wdata  out  32  memory write data
mem_be  out  4  memory byte enables; 4'b1111 for fetches and loads
mem_rdata  in  32  memory read data, valid in the mem_done cycle
mem_done  in  1  one-cycle completion pulse from memory

Behaviour:
- Reset (async): state=IDLE; starve_cnt=0; timer=0; all outputs 0.
- FSM states: IDLE, BUSY, RESP.
- IDLE: requests are sampled here only.
  - If starve_cnt>=STARVE_MAX and i_req: grant I.
  - Else if d_req: grant D.
  - Else if i_req: grant I.
  - Else stay in IDLE.
  - On grant: register owner, address, we, wdata and be into the mem_* outputs; go to BUSY next cycle.
- starve_cnt:
  - Increments (saturating at 15) on a D grant made while i_req=1.
  - Clears on any I grant.
  - Unchanged otherwise.
- BUSY:
  - mem_req=1; mem_* outputs constant.
  - timer increments each cycle.
  - On mem_done: capture mem_rdata, go to RESP.
  - If timer reaches TIMEOUT-1 without mem_done: set the abort flag, captured data=0, go to RESP.
- RESP:
  - mem_req=0.
  - Pulse the owner's ack for exactly one cycle, with its rdata = captured data. The non-owner rdata is held.
  - err=abort flag.
  - Go to IDLE; timer and abort flag clear.
  - For a store, rdata is don't-care (drive 0).
- Latency: a request seen in IDLE at cycle N gives mem_req high from N+1. If mem_done arrives at cycle M, ack is at M+1 and IDLE is reached at M+2. Minimum round trip is 3 cycles (mem_done in the first BUSY cycle).
- mem_done outside BUSY is ignored.
- A late mem_done after a timeout is ignored.
- Requests are never granted while BUSY or RESP.
- A requester dropping req early is a protocol violation; the transaction still completes and acks.
- Reset asserted mid-transaction: the transaction is abandoned, no ack is produced, and the memory-side completion is ignored.
- Never more than one ack per cycle; at most one transaction outstanding.

Test Plan:
- Single load: d_req, d_we=0, d_addr=0x10, mem_done 5 cycles after mem_req rises with mem_rdata=0xDEADBEEF -> d_ack one cycle later, d_rdata=0xDEADBEEF, err=0, mem_be=4'hF.
- Store: d_we=1, d_be=4'b0011, d_wdata=0x12345678, d_addr=0x20 -> mem_we=1, mem_be=4'b0011, mem_wdata=0x12345678 for all of BUSY; d_ack after mem_done; no i_ack.
- Simultaneous requests: i_req and d_req both held, memory latency 1 -> grant order D,D,D,D,I,D,D,D,D,I (STARVE_MAX=4); starve_cnt clears after each I grant.
- Timeout: d_req with mem_done never asserted -> d_ack and err pulse together after exactly 64 BUSY cycles with d_rdata=0. A mem_done issued afterwards produces no ack.
- Reset mid-BUSY: assert reset 2 cycles into BUSY -> outputs 0 immediately, no ack. A following mem_done is ignored; the next i_req is served normally.
- Stray mem_done in IDLE with no requests -> no ack and no state change.
